stack_cmd_sequencer: RTL and testbench

- Command initiator for the stack/ALU datapath.
- Accepts a stream of stack instructions over a valid/ready handshake.
- Drives the stack/ALU control inputs (in_val, stackAction, aluCode) with cycle-exact sequences.
- Reads back top/aluResult, tracks stack depth, flags under/overflow, and returns PEEK results over a second valid/ready port.

---
 rtl/stack_seq_pkg.sv | 43 ++++
 rtl/stack_depth_counter.sv | 50 +++++
 rtl/stack_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_stack_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// +----------------------------------------------------------------------+
// | stack_seq_pkg : opcodes, stack actions, error codes, sequencer states |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package stack_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_PUSH = 4'b0001;
  localparam logic [3:0] OP_POP  = 4'b0010;
  localparam logic [3:0] OP_ALU  = 4'b0011;
  localparam logic [3:0] OP_PEEK = 4'b0100;

  localparam logic [3:0] SA_NONE = 4'b0000;
  localparam logic [3:0] SA_PUSH = 4'b1000;
  localparam logic [3:0] SA_POP  = 4'b0001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PUSH_ISSUE = 3'd1,
    ST_POP_ISSUE  = 3'd2,
    ST_ALU_EVAL   = 3'd3,
    ST_ALU_POP1   = 3'd4,
    ST_ALU_POP2   = 3'd5,
    ST_ALU_PUSH   = 3'd6,
    ST_PEEK_OUT   = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/stack_depth_counter.sv
// +----------------------------------------------------------------------+
// | stack_depth_counter : saturating entry count with full/empty flags    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module stack_depth_counter #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       has_two_o
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] c_full = DW'(DEPTH);
  localparam logic [DW-1:0] c_one  = DW'(1);

  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (inc_i && !dec_i && (depth_q != c_full)) begin
      depth_d = depth_q + c_one;
    end else if (dec_i && !inc_i && (depth_q != '0)) begin
      depth_d = depth_q - c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  assign depth_o   = depth_q;
  assign full_o    = (depth_q == c_full);
  assign empty_o   = (depth_q == '0);
  assign has_two_o = (depth_q > c_one);

endmodule

`default_nettype wire

// File: rtl/stack_cmd_sequencer.sv
// +----------------------------------------------------------------------+
// | stack_cmd_sequencer : turns stack instructions into stack/ALU strobes |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module stack_cmd_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [3:0]                 instr_op,
  input  logic [WIDTH-1:0]           instr_imm,
  output logic [WIDTH-1:0]           in_val,
  output logic [3:0]                 stackAction,
  output logic [2:0]                 aluCode,
  input  logic [WIDTH-1:0]           top,
  input  logic [WIDTH-1:0]           next,
  input  logic [WIDTH-1:0]           aluResult,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err,
  output logic [1:0]                 err_code,
  input  logic                       err_clr
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] in_val_q, alu_res_q, res_data_q;
  logic [2:0]       alu_code_q;
  logic             res_valid_q, err_q;
  logic [1:0]       err_code_q;

  logic             w_accept, w_err_new;
  logic [1:0]       w_err_code;
  logic             w_full, w_empty, w_has_two;
  logic             unused_next;

  assign unused_next = ^next;
  assign w_accept    = instr_valid && instr_ready;

  stack_depth_counter #(
    .DEPTH(DEPTH)
  ) u_depth (
    .clk      (clk),
    .rst_n    (rst),
    .inc_i    (stackAction == SA_PUSH),
    .dec_i    (stackAction == SA_POP),
    .depth_o  (depth),
    .full_o   (w_full),
    .empty_o  (w_empty),
    .has_two_o(w_has_two)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Erroring instructions are consumed in IDLE and never leave it.
  always_comb begin
    state_d    = state_q;
    w_err_new  = 1'b0;
    w_err_code = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          case (instr_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (w_full) begin
                w_err_new  = 1'b1;
                w_err_code = ERR_OVER;
              end else begin
                state_d = ST_PUSH_ISSUE;
              end
            end
            OP_POP: begin
              if (w_empty) begin
                w_err_new  = 1'b1;
                w_err_code = ERR_UNDER;
              end else begin
                state_d = ST_POP_ISSUE;
              end
            end
            OP_ALU: begin
              if (!w_has_two) begin
                w_err_new  = 1'b1;
                w_err_code = ERR_UNDER;
              end else begin
                state_d = ST_ALU_EVAL;
              end
            end
            OP_PEEK: begin
              if (w_empty) begin
                w_err_new  = 1'b1;
                w_err_code = ERR_UNDER;
              end else begin
                state_d = ST_PEEK_OUT;
              end
            end
            default: begin
              w_err_new  = 1'b1;
              w_err_code = ERR_ILLEGAL;
            end
          endcase
        end
      end
      ST_PUSH_ISSUE: state_d = ST_IDLE;
      ST_POP_ISSUE:  state_d = ST_IDLE;
      ST_ALU_EVAL:   state_d = ST_ALU_POP1;
      ST_ALU_POP1:   state_d = ST_ALU_POP2;
      ST_ALU_POP2:   state_d = ST_ALU_PUSH;
      ST_ALU_PUSH:   state_d = ST_IDLE;
      ST_PEEK_OUT:   if (res_ready) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = rst && (state_q == ST_IDLE);
    case (state_q)
      ST_PUSH_ISSUE, ST_ALU_PUSH:             stackAction = SA_PUSH;
      ST_POP_ISSUE, ST_ALU_POP1, ST_ALU_POP2: stackAction = SA_POP;
      default:                                stackAction = SA_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_val_q    <= '0;
      alu_res_q   <= '0;
      res_data_q  <= '0;
      alu_code_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      if ((state_q == ST_IDLE) && (state_d == ST_PUSH_ISSUE)) in_val_q <= instr_imm;
      if ((state_q == ST_IDLE) && (state_d == ST_ALU_EVAL))   alu_code_q <= instr_imm[2:0];
      if ((state_q == ST_IDLE) && (state_d == ST_PEEK_OUT)) begin
        res_data_q  <= top;
        res_valid_q <= 1'b1;
      end
      // The result is captured before the pops disturb top/next.
      if (state_q == ST_ALU_EVAL) alu_res_q <= aluResult;
      if (state_q == ST_ALU_POP2) in_val_q <= alu_res_q;
      if ((state_q == ST_PEEK_OUT) && res_ready) res_valid_q <= 1'b0;

      if (w_err_new) begin
        err_q <= 1'b1;
        if (!err_q || err_clr) err_code_q <= w_err_code;
      end else if (err_clr) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
    end
  end

  assign in_val    = in_val_q;
  assign aluCode   = alu_code_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_cmd_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_stack_cmd_sequencer : scoreboard bench with stack/ALU environment  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_stack_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             instr_valid, instr_ready, res_valid, res_ready, err, err_clr;
  logic [3:0]       instr_op, stackAction;
  logic [WIDTH-1:0] instr_imm, in_val, top, next, aluResult, res_data;
  logic [2:0]       aluCode;
  logic [DW-1:0]    depth;
  logic [1:0]       err_code;

  stack_cmd_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm), .in_val(in_val),
    .stackAction(stackAction), .aluCode(aluCode), .top(top), .next(next),
    .aluResult(aluResult), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .depth(depth), .err(err), .err_code(err_code),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       act;
    logic [WIDTH-1:0] val;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] peek_q[$];
  logic [WIDTH-1:0] ref_stk[$];
  int               checks = 0, failures = 0, cyc = 0;
  bit               m_err = 1'b0, hung = 1'b0;
  logic [1:0]       m_code = 2'b00;
  bit               rr_force = 1'b0, rr_val = 1'b0;

  function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] c,
                                             input logic [WIDTH-1:0] a, b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Stack/ALU environment: a plain array stack driven by the DUT strobes.
  logic [WIDTH-1:0] env_mem [0:15];
  int               env_sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      env_sp <= 0;
    end else if (stackAction == 4'b1000 && env_sp < 16) begin
      env_mem[env_sp] <= in_val;
      env_sp          <= env_sp + 1;
    end else if (stackAction == 4'b0001 && env_sp > 0) begin
      env_sp <= env_sp - 1;
    end
  end

  always_comb begin
    top       = (env_sp > 0) ? env_mem[env_sp-1] : '0;
    next      = (env_sp > 1) ? env_mem[env_sp-2] : '0;
    aluResult = alu_f(aluCode, top, next);
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_force ? rr_val : ($urandom % 3 == 0);
    end
  end

  // Monitor: every strobe and every presented result is popped and compared.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (stackAction != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_action", {28'd0, stackAction}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("action", {28'd0, stackAction}, {28'd0, mon_e.act});
          chk("action_cycle", cyc, mon_e.cyc);
          if (mon_e.act == 4'b1000) chk("in_val", {16'd0, in_val}, {16'd0, mon_e.val});
        end
      end
      if (res_valid) begin
        if (peek_q.size() == 0) begin
          chk("unexpected_res", 32'd1, 32'd0);
        end else begin
          chk("res_data", {16'd0, res_data}, {16'd0, peek_q[0]});
          chk("ready_during_peek", {31'd0, instr_ready}, 32'd0);
          if (res_ready) void'(peek_q.pop_front());
        end
      end
    end
  end

  // Issues one instruction; called and returning at posedge+1.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] imm, input bit clr);
    int               waitc = 0;
    int               acc;
    logic [1:0]       e = 2'b00;
    logic [WIDTH-1:0] r;
    exp_t             x;
    if (hung) return;
    instr_valid = 1'b1; instr_op = op; instr_imm = imm; err_clr = clr;
    forever begin
      @(negedge clk);
      #1;
      if (instr_ready) break;
      waitc++;
      if (waitc > 200) begin
        chk("ready_timeout", 32'd0, 32'd1);
        hung = 1'b1;
        instr_valid = 1'b0; err_clr = 1'b0;
        return;
      end
    end
    chk("depth", {28'd0, depth}, ref_stk.size());
    acc = cyc;
    case (op)
      4'b0000: ;
      4'b0001: begin
        if (ref_stk.size() == DEPTH) e = 2'b10;
        else begin
          ref_stk.push_front(imm);
          x.act = 4'b1000; x.val = imm; x.cyc = acc + 1; exp_q.push_back(x);
        end
      end
      4'b0010: begin
        if (ref_stk.size() == 0) e = 2'b01;
        else begin
          void'(ref_stk.pop_front());
          x.act = 4'b0001; x.val = '0; x.cyc = acc + 1; exp_q.push_back(x);
        end
      end
      4'b0011: begin
        if (ref_stk.size() < 2) e = 2'b01;
        else begin
          r = alu_f(imm[2:0], ref_stk[0], ref_stk[1]);
          void'(ref_stk.pop_front()); void'(ref_stk.pop_front());
          ref_stk.push_front(r);
          x.act = 4'b0001; x.val = '0; x.cyc = acc + 2; exp_q.push_back(x);
          x.cyc = acc + 3; exp_q.push_back(x);
          x.act = 4'b1000; x.val = r; x.cyc = acc + 4; exp_q.push_back(x);
        end
      end
      4'b0100: begin
        if (ref_stk.size() == 0) e = 2'b01;
        else peek_q.push_back(ref_stk[0]);
      end
      default: e = 2'b11;
    endcase
    if (clr) begin m_err = 1'b0; m_code = 2'b00; end
    if (e != 2'b00 && !m_err) begin m_err = 1'b1; m_code = e; end
    @(posedge clk);
    #1;
    instr_valid = 1'b0; err_clr = 1'b0;
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("err_code", {30'd0, err_code}, {30'd0, m_code});
  endtask

  initial begin
    int r;
    logic [WIDTH-1:0] imm;
    instr_valid = 1'b0; instr_op = '0; instr_imm = '0; err_clr = 1'b0;
    #12;
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_stackAction", {28'd0, stackAction}, 32'd0);
    chk("rst_in_val", {16'd0, in_val}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_depth", {28'd0, depth}, 32'd0);
    chk("rst_err", {30'd0, err_code, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    send(4'b0001, 16'h000A, 1'b0);
    send(4'b0001, 16'h0005, 1'b0);
    send(4'b0011, 16'h0000, 1'b0);

    // PEEK held off for three cycles by the consumer.
    rr_force = 1'b1; rr_val = 1'b0;
    send(4'b0100, 16'h0000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("peek_held_valid", {31'd0, res_valid}, 32'd1);
      chk("peek_held_data", {16'd0, res_data}, 32'h000F);
    end
    rr_val = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("peek_done_valid", {31'd0, res_valid}, 32'd0);
    chk("peek_done_ready", {31'd0, instr_ready}, 32'd1);
    rr_force = 1'b0;

    send(4'b0010, 16'h0000, 1'b0);
    send(4'b0010, 16'h0000, 1'b0);
    send(4'b0001, 16'h0001, 1'b0);
    send(4'b0011, 16'h0000, 1'b0);
    send(4'b0000, 16'h0000, 1'b1);

    while (ref_stk.size() < DEPTH && !hung) send(4'b0001, 16'($urandom), 1'b0);
    send(4'b0001, 16'hBEEF, 1'b0);
    send(4'b0000, 16'h0000, 1'b1);
    send(4'b0111, 16'h0000, 1'b0);
    send(4'b0001, 16'h1234, 1'b1);
    send(4'b0000, 16'h0000, 1'b1);

    repeat (300) begin
      r   = int'($urandom % 16);
      imm = 16'($urandom);
      if (r < 5)       send(4'b0001, imm, ($urandom % 10) == 0);
      else if (r < 8)  send(4'b0010, imm, ($urandom % 10) == 0);
      else if (r < 11) send(4'b0011, imm, ($urandom % 10) == 0);
      else if (r < 13) send(4'b0100, imm, ($urandom % 10) == 0);
      else if (r < 14) send(4'b0000, imm, 1'b0);
      else if (r < 15) send(4'(5 + $urandom % 11), imm, 1'b0);
      else             send(4'b0000, imm, 1'b1);
    end

    // Reset lands while the ALU sequence is in its second pop.
    while (ref_stk.size() < 2 && !hung) send(4'b0001, 16'($urandom), 1'b0);
    send(4'b0011, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_action", {28'd0, stackAction}, 32'd0);
    chk("midrst_depth", {28'd0, depth}, 32'd0);
    chk("midrst_ready", {31'd0, instr_ready}, 32'd0);
    exp_q.delete(); peek_q.delete(); ref_stk.delete();
    m_err = 1'b0; m_code = 2'b00;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("postrst_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(4'b0001, 16'h0077, 1'b0);
    send(4'b0100, 16'h0000, 1'b0);

    for (int i = 0; i < 60 && peek_q.size() != 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("peek_q_drained", peek_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
